valve_sequencer: RTL and testbench

- Downstream stage of the irrigation-mode FSM.
- Consumes its 2-bit mode output (00 none, 10 sprinkler/aspersor, 01 drip/gotejamento) and drives the physical sprinkler valve, drip valve and pump.
- Enforces a safe sequence:
  - Start: valve opens first, pump starts after a settle time.
  - Run: pump runs for a minimum time.
  - Stop: pump stops first, valve closes after a drain time.
- Switching between modes always passes through pump-off and valve-close. Two valves are never open at once.

---
 rtl/valve_sequencer.sv | 137 +++++++++++++
 tb/tb_valve_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/valve_sequencer.sv
// Sequences sprinkler/drip valves and pump: valve before pump, pump before valve.
// Latency: outputs registered, one CLK edge from sampled cmd to first output change.
// Backpressure: none; cmd is a level, changes are held off until min-run and drain complete.
module valve_sequencer #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned MIN_RUN_CYC = 8,
  parameter int unsigned DRAIN_CYC   = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] cmd,
  output logic       valve_asp,
  output logic       valve_got,
  output logic       pump,
  output logic       busy,
  output logic [1:0] state_o,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OPENING  = 2'b01,
    RUNNING  = 2'b10,
    STOPPING = 2'b11
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] RUN_LAST    = 16'(MIN_RUN_CYC - 1);
  localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYC - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  tgt, tgt_n;
  logic        valve_asp_n, valve_got_n, pump_n, err_n;
  logic [1:0]  eff_cmd;

  // Illegal 11 sequences exactly like "none"; it only raises the sticky error.
  assign eff_cmd = (cmd == 2'b11) ? 2'b00 : cmd;

  assign busy    = (state != IDLE);
  assign state_o = state;

  // State, counter, target and registered outputs; reset drops everything at once.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tgt       <= 2'b00;
      valve_asp <= 1'b0;
      valve_got <= 1'b0;
      pump      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tgt       <= tgt_n;
      valve_asp <= valve_asp_n;
      valve_got <= valve_got_n;
      pump      <= pump_n;
      err       <= err_n;
    end
  end

  // Next-state and next-output logic; every branch starts from "hold".
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tgt_n       = tgt;
    valve_asp_n = valve_asp;
    valve_got_n = valve_got;
    pump_n      = pump;
    err_n       = err | (cmd == 2'b11);

    unique case (state)
      IDLE: begin
        valve_asp_n = 1'b0;
        valve_got_n = 1'b0;
        pump_n      = 1'b0;
        if (eff_cmd == 2'b10 || eff_cmd == 2'b01) begin
          tgt_n       = eff_cmd;
          valve_asp_n = eff_cmd[1];
          valve_got_n = eff_cmd[0];
          cnt_n       = '0;
          state_n     = OPENING;
        end
      end

      OPENING: begin
        // cmd is deliberately ignored while the valve settles.
        if (cnt == SETTLE_LAST) begin
          pump_n  = 1'b1;
          cnt_n   = '0;
          state_n = RUNNING;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      RUNNING: begin
        // A stop/change requested early is honoured once the minimum run elapses.
        if (cnt == RUN_LAST) begin
          if (eff_cmd != tgt) begin
            pump_n  = 1'b0;
            cnt_n   = '0;
            state_n = STOPPING;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      STOPPING: begin
        if (cnt == DRAIN_LAST) begin
          cnt_n = '0;
          if (eff_cmd == 2'b00) begin
            valve_asp_n = 1'b0;
            valve_got_n = 1'b0;
            tgt_n       = 2'b00;
            state_n     = IDLE;
          end else begin
            // Old valve closes and new one opens on the same edge; if the
            // target is unchanged the valve simply stays open.
            valve_asp_n = eff_cmd[1];
            valve_got_n = eff_cmd[0];
            tgt_n       = eff_cmd;
            state_n     = OPENING;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_valve_sequencer.sv
// Directed bench for valve_sequencer with default timing parameters.
// Latency: checks are taken 1 ns after each rising edge, invariants on falling edges.
// Backpressure: not applicable; cmd is driven as a level between edges.
module tb_valve_sequencer;

  logic       CLK;
  logic       reset;
  logic [1:0] cmd;
  logic       valve_asp, valve_got, pump, busy, err;
  logic [1:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  valve_sequencer dut (
    .CLK       (CLK),
    .reset     (reset),
    .cmd       (cmd),
    .valve_asp (valve_asp),
    .valve_got (valve_got),
    .pump      (pump),
    .busy      (busy),
    .state_o   (state_o),
    .err       (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Safety invariants sampled mid-cycle on every clock.
  always @(negedge CLK) begin
    check("inv_two_valves", 16'(valve_asp & valve_got), 16'd0);
    check("inv_pump_valve", 16'(pump & ~(valve_asp ^ valve_got)), 16'd0);
    check("inv_busy", 16'(busy), 16'(state_o != 2'b00));
  end

  initial begin
    // Reset held with a live command: nothing may move.
    reset = 1'b0;
    cmd   = 2'b10;
    repeat (5) tick();
    check("rst_asp",   16'(valve_asp), 16'd0);
    check("rst_got",   16'(valve_got), 16'd0);
    check("rst_pump",  16'(pump),      16'd0);
    check("rst_busy",  16'(busy),      16'd0);
    check("rst_state", 16'(state_o),   16'd0);
    check("rst_err",   16'(err),       16'd0);
    cmd   = 2'b00;
    reset = 1'b1;
    tick();
    check("idle_state", 16'(state_o), 16'd0);

    // Start sprinkler: valve at E, pump at E+4.
    cmd = 2'b10;
    tick();
    check("start_asp",   16'(valve_asp), 16'd1);
    check("start_busy",  16'(busy),      16'd1);
    check("start_state", 16'(state_o),   16'd1);
    check("start_pump",  16'(pump),      16'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("settle_pump", 16'(pump),      16'(i == 4));
      check("settle_got",  16'(valve_got), 16'd0);
    end
    check("run_state", 16'(state_o), 16'd2);

    // Min-run hold-off: stop requested at P+1, pump off at P+8, valve off at P+11.
    cmd = 2'b00;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("hold_pump", 16'(pump),      16'(i < 8));
      check("hold_asp",  16'(valve_asp), 16'(i < 11));
    end
    check("hold_state", 16'(state_o), 16'd0);
    check("hold_busy",  16'(busy),    16'd0);

    // Mode switch sprinkler -> drip after min-run.
    cmd = 2'b10;
    repeat (5) tick();
    check("sw_run_pump", 16'(pump), 16'd1);
    repeat (10) tick();
    cmd = 2'b01;
    tick();
    check("sw_q_pump",  16'(pump),    16'd0);
    check("sw_q_state", 16'(state_o), 16'd3);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("sw_asp",  16'(valve_asp), 16'(i < 3));
      check("sw_got",  16'(valve_got), 16'(i >= 3));
      check("sw_pump", 16'(pump),      16'(i == 7));
    end

    // Illegal command while drip runs past min-run: stops like 00, err sticks.
    repeat (10) tick();
    cmd = 2'b11;
    tick();
    check("ill_err",   16'(err),     16'd1);
    check("ill_pump",  16'(pump),    16'd0);
    check("ill_state", 16'(state_o), 16'd3);
    cmd = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("ill_got", 16'(valve_got), 16'(i < 3));
      check("ill_err_hold", 16'(err), 16'd1);
    end
    check("ill_idle", 16'(state_o), 16'd0);

    // cmd toggling during the settle window is ignored.
    cmd = 2'b10;
    tick();
    check("tog_asp", 16'(valve_asp), 16'd1);
    cmd = 2'b01; tick();
    cmd = 2'b10; tick();
    cmd = 2'b01; tick();
    check("tog_got_mid", 16'(valve_got), 16'd0);
    cmd = 2'b10; tick();
    check("tog_pump", 16'(pump),      16'd1);
    check("tog_asp4", 16'(valve_asp), 16'd1);
    check("tog_got",  16'(valve_got), 16'd0);

    // Asynchronous reset mid-cycle while running drops everything before the next edge.
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_pump",  16'(pump),      16'd0);
    check("arst_asp",   16'(valve_asp), 16'd0);
    check("arst_got",   16'(valve_got), 16'd0);
    check("arst_state", 16'(state_o),   16'd0);
    check("arst_err",   16'(err),       16'd0);
    cmd = 2'b00;
    @(negedge CLK);
    reset = 1'b1;
    tick();
    check("post_rst_state", 16'(state_o), 16'd0);
    check("post_rst_err",   16'(err),     16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
